// File: rtl/serial_sample_capture_pkg.sv
// ---------------------------------------------------------------------------
// serial_capture_pkg
// Shared constants and helpers for the serial sample capture block.
//    LATCH_FALL / LATCH_RISE : values for the LATCH_EDGE parameter
//    MODE_TRUNC / MODE_ROUND : values for the ROUND parameter
//    width_ok()              : legality check on the input/output word widths
// ---------------------------------------------------------------------------
package serial_capture_pkg;

   localparam int LATCH_FALL = 0;
   localparam int LATCH_RISE = 1;
   localparam int MODE_TRUNC = 0;
   localparam int MODE_ROUND = 1;

   // The output can never be wider than the serial word. The shift register
   // also needs at least two bits so that its lower slice is well formed.
   function automatic bit width_ok(input int in_width, input int out_width);
      return (in_width >= 2) && (out_width >= 1) && (out_width <= in_width);
   endfunction

endpackage

// File: rtl/serial_sample_capture_if.sv
// ---------------------------------------------------------------------------
// serial_sample_capture_if
// Bundles the serial receive pins and the parallel sample outputs.
//    i_latch : word-select / latch strobe, sampled every clock
//    i_data  : one serial bit per channel, bit k = channel k
//    o_data  : parallel samples, channel k at [k*OUT_WIDTH +: OUT_WIDTH]
//    o_valid : one-cycle pulse when o_data has been updated
//    o_short : one-cycle pulse when a latch event arrived on a partial word
// master = the side driving the pins, slave = the capture block.
// ---------------------------------------------------------------------------
interface serial_sample_capture_if #(
   parameter int CHANNELS  = 2,
   parameter int OUT_WIDTH = 16
);

   logic                          i_latch;
   logic [CHANNELS-1:0]           i_data;
   logic [CHANNELS*OUT_WIDTH-1:0] o_data;
   logic                          o_valid;
   logic                          o_short;

   modport master (
      output i_latch, i_data,
      input  o_data, o_valid, o_short
   );

   modport slave (
      input  i_latch, i_data,
      output o_data, o_valid, o_short
   );

endinterface

// File: rtl/serial_sample_lane.sv
// ---------------------------------------------------------------------------
// serial_sample_lane
// One serial data lane: an MSB-first shift register plus the conversion from
// the IN_WIDTH serial word to an OUT_WIDTH sample (truncate, or round half-up
// with saturation at positive full scale).
//    clk     : bit clock
//    rst_n   : synchronous reset, active low
//    bit_in  : serial data bit for this lane
//    load_en : copy the converted pre-shift word into sample on this edge
//    sample  : registered parallel output sample
// ---------------------------------------------------------------------------
module serial_sample_lane
   import serial_capture_pkg::*;
#(
   parameter int IN_WIDTH  = 18,
   parameter int OUT_WIDTH = 16,
   parameter int ROUND     = MODE_TRUNC
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 bit_in,
   input  logic                 load_en,
   output logic [OUT_WIDTH-1:0] sample
);

   localparam int DROP = IN_WIDTH - OUT_WIDTH;

   logic [IN_WIDTH-1:0]  shift;
   logic [OUT_WIDTH-1:0] upper;
   logic [OUT_WIDTH-1:0] converted;

   assign upper = shift[IN_WIDTH-1 -: OUT_WIDTH];

   // Conversion is purely combinational on the current (pre-shift) register,
   // which is exactly the completed word on a latch event clock.
   generate
      if (DROP == 0) begin : g_pass
         assign converted = upper;
      end else if (ROUND == MODE_ROUND) begin : g_round
         logic [OUT_WIDTH:0] sum;
         // Sign-extend by one bit so the carry out of the rounding add is
         // visible; the two top bits disagree only when a non-negative word
         // rounds past the positive maximum.
         assign sum = {upper[OUT_WIDTH-1], upper} + {{OUT_WIDTH{1'b0}}, shift[DROP-1]};
         assign converted = (sum[OUT_WIDTH] != sum[OUT_WIDTH-1])
                          ? {1'b0, {(OUT_WIDTH-1){1'b1}}}
                          : sum[OUT_WIDTH-1:0];
      end else begin : g_trunc
         assign converted = upper;
      end
   endgenerate

   // The shift register runs every clock, including latch event clocks: the
   // bit arriving with the event is the first bit of the following word.
   // The sample register only moves when the top block says the word is full.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift  <= '0;
         sample <= '0;
      end else begin
         shift <= {shift[IN_WIDTH-2:0], bit_in};
         if (load_en) begin
            sample <= converted;
         end
      end
   end

endmodule

// File: rtl/serial_sample_capture.sv
// ---------------------------------------------------------------------------
// serial_sample_capture
// Multi-channel serial-to-parallel capture for DAC input streams. All lanes
// share one latch-edge detector and one bit counter, so every lane updates on
// the same edge. A latch event on a complete word produces o_valid one cycle
// later; a latch event on a partial word produces o_short instead and leaves
// o_data untouched.
//    i_clk   : bit clock, all logic on posedge
//    i_rst_n : synchronous reset, active low
//    bus     : slave side of serial_sample_capture_if (i_latch, i_data in;
//              o_data, o_valid, o_short out)
// ---------------------------------------------------------------------------
module serial_sample_capture
   import serial_capture_pkg::*;
#(
   parameter int CHANNELS   = 2,
   parameter int IN_WIDTH   = 18,
   parameter int OUT_WIDTH  = 16,
   parameter int LATCH_EDGE = LATCH_FALL,
   parameter int ROUND      = MODE_TRUNC
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   serial_sample_capture_if.slave bus
);

   localparam int                CW   = $clog2(IN_WIDTH + 1);
   localparam logic [CW-1:0]     FULL = CW'(IN_WIDTH);
   localparam logic              LATCH_IDLE = (LATCH_EDGE == LATCH_RISE);

   generate
      if (!width_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_width
         $error("serial_sample_capture: OUT_WIDTH must not exceed IN_WIDTH");
      end
   endgenerate

   logic                          r_latch_d;
   logic                          latch_event;
   logic [CW-1:0]                 bit_count;
   logic                          word_full;
   logic                          load_en;
   logic [CHANNELS*OUT_WIDTH-1:0] data_bus;

   // Edge detect against the previous latch sample. The delay register resets
   // to the idle level of the selected edge so reset release never fires.
   assign latch_event = (LATCH_EDGE == LATCH_RISE) ? (~r_latch_d &  bus.i_latch)
                                                   : ( r_latch_d & ~bus.i_latch);
   assign word_full   = (bit_count >= FULL);
   assign load_en     = latch_event & word_full;

   // Delay register, bit counter and the two status pulses. The counter
   // restarts at 1 on an event because that clock already shifts in the
   // first bit of the next word; otherwise it counts up and parks at FULL.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_latch_d   <= LATCH_IDLE;
         bit_count   <= '0;
         bus.o_valid <= 1'b0;
         bus.o_short <= 1'b0;
      end else begin
         r_latch_d   <= bus.i_latch;
         bus.o_valid <= load_en;
         bus.o_short <= latch_event & ~word_full;
         if (latch_event) begin
            bit_count <= CW'(1);
         end else if (!word_full) begin
            bit_count <= bit_count + CW'(1);
         end
      end
   end

   // One lane per channel, all loading from the shared enable.
   generate
      for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
         serial_sample_lane #(
            .IN_WIDTH  (IN_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .ROUND     (ROUND)
         ) u_lane (
            .clk     (i_clk),
            .rst_n   (i_rst_n),
            .bit_in  (bus.i_data[k]),
            .load_en (load_en),
            .sample  (data_bus[k*OUT_WIDTH +: OUT_WIDTH])
         );
      end
   endgenerate

   assign bus.o_data = data_bus;

endmodule

// File: tb/tb_serial_sample_capture.sv
// ---------------------------------------------------------------------------
// tb_serial_sample_capture
// Drives three capture instances: a default truncating one and a rounding one
// sharing the same 2-lane 18-bit stream, and a 4-lane 24-bit rising-edge
// pass-through one. The 2-lane instances are checked every clock against a
// reference built from the stream history and plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_serial_sample_capture;
   import serial_capture_pkg::*;

   localparam int IW = 18;
   localparam int OW = 16;
   localparam int SH = IW - OW;
   localparam int WW = 24;

   logic clk = 1'b0;
   logic rstN;
   int   checks = 0;
   int   errors = 0;

   serial_sample_capture_if #(.CHANNELS(2), .OUT_WIDTH(OW)) truncBus ();
   serial_sample_capture_if #(.CHANNELS(2), .OUT_WIDTH(OW)) roundBus ();
   serial_sample_capture_if #(.CHANNELS(4), .OUT_WIDTH(WW)) wideBus ();

   assign roundBus.i_latch = truncBus.i_latch;
   assign roundBus.i_data  = truncBus.i_data;

   serial_sample_capture #(
      .CHANNELS(2), .IN_WIDTH(IW), .OUT_WIDTH(OW), .LATCH_EDGE(LATCH_FALL), .ROUND(MODE_TRUNC)
   ) dutTrunc (.i_clk(clk), .i_rst_n(rstN), .bus(truncBus));

   serial_sample_capture #(
      .CHANNELS(2), .IN_WIDTH(IW), .OUT_WIDTH(OW), .LATCH_EDGE(LATCH_FALL), .ROUND(MODE_ROUND)
   ) dutRound (.i_clk(clk), .i_rst_n(rstN), .bus(roundBus));

   serial_sample_capture #(
      .CHANNELS(4), .IN_WIDTH(WW), .OUT_WIDTH(WW), .LATCH_EDGE(LATCH_RISE), .ROUND(MODE_TRUNC)
   ) dutWide (.i_clk(clk), .i_rst_n(rstN), .bus(wideBus));

   always #5 clk = ~clk;

   // Reference model state: the serial bits seen since reset (last IW kept),
   // how many bits arrived since the last event, and the expected outputs.
   bit          histQ [2][$];
   int          bitsSince;
   logic        prevLatch;
   logic [15:0] expTrunc [2];
   logic [15:0] expRound [2];
   logic        expValid;
   logic        expShort;
   int          validCount;
   int          shortCount;
   logic        capValid;
   logic        capShort;
   logic [31:0] capTrunc;
   logic [31:0] capRound;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Floor division by 2^SH of the signed word.
   function automatic logic [15:0] truncRef(input logic [IW-1:0] w);
      int s;
      s = int'(signed'(w));
      return 16'(s >>> SH);
   endfunction

   // Round half-up: floor((s + half) / 2^SH), clipped at the positive maximum.
   function automatic logic [15:0] roundRef(input logic [IW-1:0] w);
      int s;
      int r;
      s = int'(signed'(w));
      r = (s + (1 << (SH - 1))) >>> SH;
      if (r > 32767) r = 32767;
      return 16'(r);
   endfunction

   function automatic logic [IW-1:0] wordFromHist(input int ch);
      logic [IW-1:0] w;
      w = '0;
      foreach (histQ[ch][i]) w = (w << 1) | IW'(histQ[ch][i]);
      return w;
   endfunction

   // One clock on the 2-lane stream, followed by the model update and checks.
   task automatic applyStimulus(input logic latch, input logic [1:0] data, input logic rstVal);
      logic          evt;
      logic [IW-1:0] w;
      truncBus.i_latch = latch;
      truncBus.i_data  = data;
      rstN             = rstVal;
      @(posedge clk);
      #1;
      if (!rstVal) begin
         bitsSince = 0;
         prevLatch = 1'b0;
         expValid  = 1'b0;
         expShort  = 1'b0;
         for (int ch = 0; ch < 2; ch++) begin
            histQ[ch].delete();
            expTrunc[ch] = '0;
            expRound[ch] = '0;
         end
      end else begin
         evt      = prevLatch & ~latch;
         expValid = 1'b0;
         expShort = 1'b0;
         if (evt) begin
            if (bitsSince >= IW) begin
               expValid = 1'b1;
               for (int ch = 0; ch < 2; ch++) begin
                  w            = wordFromHist(ch);
                  expTrunc[ch] = truncRef(w);
                  expRound[ch] = roundRef(w);
               end
            end else begin
               expShort = 1'b1;
            end
            bitsSince = 1;
         end else if (bitsSince < IW) begin
            bitsSince++;
         end
         for (int ch = 0; ch < 2; ch++) begin
            histQ[ch].push_back(data[ch]);
            if (histQ[ch].size() > IW) void'(histQ[ch].pop_front());
         end
         prevLatch = latch;
      end
      if (truncBus.o_valid) validCount++;
      if (truncBus.o_short) shortCount++;
      checkOutput("trunc_valid", 64'(truncBus.o_valid), 64'(expValid));
      checkOutput("trunc_short", 64'(truncBus.o_short), 64'(expShort));
      checkOutput("trunc_data",  64'(truncBus.o_data),  64'({expTrunc[1], expTrunc[0]}));
      checkOutput("round_valid", 64'(roundBus.o_valid), 64'(expValid));
      checkOutput("round_short", 64'(roundBus.o_short), 64'(expShort));
      checkOutput("round_data",  64'(roundBus.o_data),  64'({expRound[1], expRound[0]}));
   endtask

   // A frame of len bits MSB-first; the first clock carries the falling-edge
   // event that closes the previous frame. Outputs after that clock are kept.
   task automatic sendFrame(input logic [IW-1:0] w0, input logic [IW-1:0] w1, input int len);
      for (int i = 0; i < len; i++) begin
         applyStimulus((i == 0) ? 1'b0 : 1'b1, {w1[len-1-i], w0[len-1-i]}, 1'b1);
         if (i == 0) begin
            capValid = truncBus.o_valid;
            capShort = truncBus.o_short;
            capTrunc = truncBus.o_data;
            capRound = roundBus.o_data;
         end
      end
   endtask

   task automatic wideClock(input logic latch, input logic [3:0] data, input logic rstVal);
      wideBus.i_latch = latch;
      wideBus.i_data  = data;
      rstN            = rstVal;
      @(posedge clk);
      #1;
   endtask

   // 24-bit frame on four lanes: latch high for the first half (rising edge
   // on clock 0 is the event), low for the second half (falling edge, no event).
   task automatic wideFrame(input logic [WW-1:0] w [4]);
      logic [3:0] bits;
      for (int i = 0; i < WW; i++) begin
         for (int k = 0; k < 4; k++) bits[k] = w[k][WW-1-i];
         wideClock((i < WW / 2) ? 1'b1 : 1'b0, bits, 1'b1);
         if (i == 0) begin
            capValid = wideBus.o_valid;
            capShort = wideBus.o_short;
         end
         if (i == WW / 2) begin
            checkOutput("wide_fall_no_event", 64'({wideBus.o_valid, wideBus.o_short}), 64'd0);
         end
      end
   endtask

   initial begin
      logic [WW-1:0] wideA [4];
      logic [WW-1:0] wideB [4];
      logic [WW-1:0] wideC [4];

      truncBus.i_latch = 1'b1;
      truncBus.i_data  = '0;
      wideBus.i_latch  = 1'b0;
      wideBus.i_data   = '0;
      rstN             = 1'b0;
      validCount       = 0;
      shortCount       = 0;

      // Reset state.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00, 1'b0);
      applyStimulus(1'b1, 2'b00, 1'b1);

      // First event after reset is short; then the directed truncate/round words.
      sendFrame(IW'($urandom), IW'($urandom), IW);
      checkOutput("first_event_short", 64'(capShort), 64'd1);
      sendFrame(18'h12345, 18'h3FFFC, IW);
      sendFrame(18'h12347, 18'h1FFFE, IW);
      checkOutput("dir_trunc_valid", 64'(capValid), 64'd1);
      checkOutput("dir_trunc_words", 64'(capTrunc), 64'h0000_0000_FFFF_48D1);
      sendFrame(18'h3FFFE, 18'h3FFFE, IW);
      checkOutput("dir_round_words", 64'(capRound), 64'h0000_0000_7FFF_48D2);
      sendFrame(IW'($urandom), IW'($urandom), 10);
      checkOutput("dir_round_neg", 64'(capRound), 64'h0000_0000_0000_0000);

      // Short frame: status pulse only, sample held.
      sendFrame(IW'($urandom), IW'($urandom), IW);
      checkOutput("short_pulse", 64'({capValid, capShort}), 64'b01);
      checkOutput("short_hold",  64'(capTrunc), 64'h0000_0000_FFFF_FFFF);
      sendFrame(IW'($urandom), IW'($urandom), IW);

      // Reset in the middle of a word.
      sendFrame(IW'($urandom), IW'($urandom), 7);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'($urandom), 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'($urandom), 1'b1);
      sendFrame(18'h2AAAA, 18'h15555, IW);
      checkOutput("post_reset_short", 64'({capValid, capShort}), 64'b01);
      sendFrame(IW'($urandom), IW'($urandom), IW);
      checkOutput("post_reset_valid", 64'({capValid, capShort}), 64'b10);
      checkOutput("post_reset_word",  64'(capTrunc), 64'h0000_0000_5555_AAAA);

      // Back-to-back frames at exact word spacing with random data.
      validCount = 0;
      shortCount = 0;
      for (int f = 0; f < 8; f++) sendFrame(IW'($urandom), IW'($urandom), IW);
      checkOutput("b2b_valid_count", 64'(validCount), 64'd8);
      checkOutput("b2b_short_count", 64'(shortCount), 64'd0);

      // Four-lane rising-edge pass-through.
      wideA[0] = 24'hABCDEF;
      wideA[1] = 24'h123456;
      wideA[2] = 24'h800001;
      wideA[3] = 24'h7FFFFE;
      for (int k = 0; k < 4; k++) begin
         wideB[k] = WW'($urandom);
         wideC[k] = WW'($urandom);
      end
      for (int i = 0; i < 2; i++) wideClock(1'b0, 4'h0, 1'b0);
      checkOutput("wide_reset", 64'({wideBus.o_data, wideBus.o_valid, wideBus.o_short}), 64'd0);
      wideClock(1'b0, 4'h0, 1'b1);
      wideFrame(wideA);
      checkOutput("wide_first_short", 64'({capValid, capShort}), 64'b01);
      wideFrame(wideB);
      checkOutput("wide_valid_a", 64'({capValid, capShort}), 64'b10);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("wide_lane%0d_a", k), 64'(wideBus.o_data[k*WW +: WW]), 64'(wideA[k]));
      end
      wideFrame(wideC);
      checkOutput("wide_valid_b", 64'({capValid, capShort}), 64'b10);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("wide_lane%0d_b", k), 64'(wideBus.o_data[k*WW +: WW]), 64'(wideB[k]));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
